score_display_ctrl: RTL and testbench

//  Sequences the 16x20 digit glyph generator so it renders a multi-digit decimal value on the VGA raster.
//  - Accepts a binary value through a valid/ready handshake.
//  - Converts it to BCD with an iterative double-dabble, one shift per clock.
//  - Commits the new digits only at a frame boundary, so the display never tears.
//  - Every pixel, it selects which digit slot covers (sx,sy) and drives the glyph generator's position and number inputs.

---
 rtl/score_display_ctrl.sv | 150 +++++++++++++++
 tb/tb_score_display_ctrl.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_display_ctrl.sv
// score_display_ctrl
// Takes a binary value through a valid/ready handshake and converts it to BCD
// with a double-dabble that shifts one bit per clock. The digits are committed
// to the display register only on a frame pulse, so the picture never tears.
// Each pixel, the slot covering (sx,sy) is found and the glyph generator is
// given that slot's position and digit.
module score_display_ctrl #(
  parameter int DIGITS   = 4,
  parameter int BIN_W    = 14,
  parameter int DIGIT_W  = 16,
  parameter int DIGIT_H  = 20,
  parameter int GAP      = 4,
  parameter int LZ_BLANK = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [9:0]       i_sx,
  input  logic [9:0]       i_sy,
  input  logic             i_frame,
  input  logic [9:0]       i_originX,
  input  logic [9:0]       i_originY,
  input  logic [BIN_W-1:0] i_value,
  input  logic             i_valueValid,
  output logic             o_valueReady,
  output logic             o_busy,
  output logic [9:0]       o_digitX,
  output logic [9:0]       o_digitY,
  output logic [3:0]       o_digit,
  output logic             o_digitEn
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int PITCH = DIGIT_W + GAP;
  localparam logic [31:0] MAX_VAL = 32'(10 ** DIGITS - 1);
  localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'd9}};

  typedef enum logic [1:0] {IDLE, CONV, PEND} state_t;

  state_t             r_state;
  logic [BIN_W-1:0]   r_bin;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sat;
  logic [BCD_W-1:0]   r_disp;
  logic               r_ready;
  logic               r_busy;
  logic [BCD_W-1:0]   w_adj;

  // Double-dabble correction: any nibble of 5 or more gets 3 added so the
  // following left shift carries correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] addThree(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) begin
        res[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

  // Corrected accumulator that the current shift consumes.
  always_comb begin
    w_adj = addThree(r_bcd);
  end

  // Handshake, conversion sequencer and frame-synchronous commit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
      r_disp  <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_valueValid && r_ready) begin
            r_bin   <= i_value;
            r_bcd   <= '0;
            r_sat   <= (32'(i_value) > MAX_VAL);
            r_cnt   <= CNT_W'(BIN_W);
            r_state <= CONV;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        CONV: begin
          r_bcd <= {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
          r_bin <= {r_bin[BIN_W-2:0], 1'b0};
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= PEND;
          end
        end
        PEND: begin
          if (i_frame) begin
            r_disp  <= r_sat ? ALL_NINES : r_bcd;
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_valueReady = r_ready;
  assign o_busy       = r_busy;

  // Pixel-to-slot mapping; leading-zero blanking tracks whether every digit
  // up to and including the current slot is zero.
  always_comb begin : slotMap
    logic       zeroRun;
    logic       inX;
    logic       inY;
    logic [9:0] slotStart;
    logic [3:0] slotDigit;
    o_digitEn = 1'b0;
    o_digit   = 4'd0;
    o_digitX  = i_originX;
    o_digitY  = i_originY;
    zeroRun   = 1'b1;
    inX       = 1'b0;
    slotStart = i_originX;
    slotDigit = 4'd0;
    inY = (i_sy >= i_originY) && ((i_sy - i_originY) < 10'(DIGIT_H));
    for (int i = 0; i < DIGITS; i++) begin
      slotStart = i_originX + 10'(i * PITCH);
      slotDigit = r_disp[BCD_W-4-4*i +: 4];
      zeroRun   = zeroRun && (slotDigit == 4'd0);
      inX = (i_sx >= slotStart) && ((i_sx - slotStart) < 10'(DIGIT_W));
      if (inX && inY) begin
        o_digitX  = slotStart;
        o_digit   = slotDigit;
        o_digitEn = !((LZ_BLANK != 0) && (i < DIGITS - 1) && zeroRun);
      end
    end
  end

endmodule

// File: tb/tb_score_display_ctrl.sv
// tb_score_display_ctrl
// Drives two controllers (leading-zero blanking on and off) with the same
// stimulus and compares them against a decimal/arithmetic model of the screen.
module tb_score_display_ctrl;

  localparam int BIN_W = 14;

  logic             clk = 1'b0;
  logic             rst;
  logic [9:0]       sxIn, syIn, originX, originY;
  logic             frame;
  logic [BIN_W-1:0] value;
  logic             valueValid;

  logic readyA, busyA, enA, readyB, busyB, enB;
  logic [9:0] xA, yA, xB, yB;
  logic [3:0] digA, digB;
  logic [24:0] gotA, gotB;

  int tests = 0;
  int fails = 0;
  int shown = 0;
  int ox = 100;
  int oy = 50;

  assign gotA = {enA, digA, xA, yA};
  assign gotB = {enB, digB, xB, yB};

  // Pixel clock.
  always #5 clk = ~clk;

  score_display_ctrl dutLz (
    .i_clk(clk), .i_rst(rst), .i_sx(sxIn), .i_sy(syIn), .i_frame(frame),
    .i_originX(originX), .i_originY(originY), .i_value(value),
    .i_valueValid(valueValid), .o_valueReady(readyA), .o_busy(busyA),
    .o_digitX(xA), .o_digitY(yA), .o_digit(digA), .o_digitEn(enA)
  );

  score_display_ctrl #(.LZ_BLANK(0)) dutNoLz (
    .i_clk(clk), .i_rst(rst), .i_sx(sxIn), .i_sy(syIn), .i_frame(frame),
    .i_originX(originX), .i_originY(originY), .i_value(value),
    .i_valueValid(valueValid), .o_valueReady(readyB), .o_busy(busyB),
    .o_digitX(xB), .o_digitY(yB), .o_digit(digB), .o_digitEn(enB)
  );

  // Screen model: decimal digits by division, slot by pitch arithmetic,
  // blanking by comparing the shown value against powers of ten.
  function automatic logic [24:0] pixelModel(input int sx, input int sy,
      input int orgX, input int orgY, input int val, input bit lz);
    int d[4];
    int v, dx, s;
    logic en;
    logic [3:0] dig;
    logic [9:0] x;
    v = val;
    for (int k = 3; k >= 0; k--) begin
      d[k] = v % 10;
      v = v / 10;
    end
    en = 1'b0;
    dig = 4'd0;
    x = 10'(orgX);
    if (sx >= orgX && sy >= orgY && sy < orgY + 20) begin
      dx = sx - orgX;
      s = dx / 20;
      if (s < 4 && (dx % 20) < 16) begin
        x = 10'(orgX + s * 20);
        dig = 4'(d[s]);
        en = !(lz && s < 3 && val < 10 ** (3 - s));
      end
    end
    return {en, dig, x, 10'(orgY)};
  endfunction

  function automatic int satModel(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic applyStimulus(input int v);
    value = BIN_W'(v);
    valueValid = 1'b1;
    step(1);
    valueValid = 1'b0;
  endtask

  task automatic pulseFrame();
    frame = 1'b1;
    step(1);
    frame = 1'b0;
  endtask

  task automatic setPixel(input int sx, input int sy);
    sxIn = 10'(sx);
    syIn = 10'(sy);
    #1;
  endtask

  task automatic setOrigin(input int x, input int y);
    ox = x;
    oy = y;
    originX = 10'(x);
    originY = 10'(y);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    frame = 1'b0;
    valueValid = 1'b0;
    value = '0;
    setOrigin(100, 50);
    setPixel(0, 0);
    step(2);
    rst = 1'b0;
    step(1);
    shown = 0;
    tests++;
    if ({readyA, busyA, readyB, busyB} !== 4'b1010) begin
      fails++;
      $display("[TB] FAIL reset_handshake got=%b want=1010", {readyA, busyA, readyB, busyB});
    end
    setPixel(160, 55);
    tests++;
    if (gotA !== {1'b1, 4'd0, 10'd160, 10'd50}) begin
      fails++;
      $display("[TB] FAIL reset_last_slot got=%h want=%h", gotA, {1'b1, 4'd0, 10'd160, 10'd50});
    end
    setPixel(100, 55);
    tests++;
    if (gotA !== {1'b0, 4'd0, 10'd100, 10'd50}) begin
      fails++;
      $display("[TB] FAIL reset_blank_slot0 got=%h want=%h", gotA, {1'b0, 4'd0, 10'd100, 10'd50});
    end
    tests++;
    if (gotB !== {1'b1, 4'd0, 10'd100, 10'd50}) begin
      fails++;
      $display("[TB] FAIL reset_nolz_slot0 got=%h want=%h", gotB, {1'b1, 4'd0, 10'd100, 10'd50});
    end
    step(1);
  endtask

  task automatic test_load_1234();
    tests++;
    if (readyA !== 1'b1) begin
      fails++;
      $display("[TB] FAIL load_ready_before got=%b want=1", readyA);
    end
    applyStimulus(1234);
    setPixel(ox + 60, oy + 5);
    for (int c = 1; c <= 19; c++) begin
      tests++;
      if ({readyA, busyA, gotA} !== {2'b01, pixelModel(ox + 60, oy + 5, ox, oy, shown, 1'b1)}) begin
        fails++;
        $display("[TB] FAIL load_wait cycle=%0d got=%b_%h want=01_%h", c, {readyA, busyA}, gotA,
                 pixelModel(ox + 60, oy + 5, ox, oy, shown, 1'b1));
      end
      step(1);
    end
    pulseFrame();
    shown = 1234;
    tests++;
    if ({readyA, busyA, readyB, busyB} !== 4'b1010) begin
      fails++;
      $display("[TB] FAIL load_commit_handshake got=%b want=1010", {readyA, busyA, readyB, busyB});
    end
    setPixel(115, 55);
    tests++;
    if (gotA !== {1'b1, 4'd1, 10'd100, 10'd50}) begin
      fails++;
      $display("[TB] FAIL load_slot0_edge got=%h want=%h", gotA, {1'b1, 4'd1, 10'd100, 10'd50});
    end
    setPixel(120, 55);
    tests++;
    if (gotA !== {1'b1, 4'd2, 10'd120, 10'd50}) begin
      fails++;
      $display("[TB] FAIL load_slot1_start got=%h want=%h", gotA, {1'b1, 4'd2, 10'd120, 10'd50});
    end
    for (int sx = ox - 2; sx <= ox + 81; sx++) begin
      setPixel(sx, oy + 3);
      tests += 2;
      if (gotA !== pixelModel(sx, oy + 3, ox, oy, shown, 1'b1)) begin
        fails++;
        $display("[TB] FAIL load_sweep_lz sx=%0d got=%h want=%h", sx, gotA, pixelModel(sx, oy + 3, ox, oy, shown, 1'b1));
      end
      if (gotB !== pixelModel(sx, oy + 3, ox, oy, shown, 1'b0)) begin
        fails++;
        $display("[TB] FAIL load_sweep_nolz sx=%0d got=%h want=%h", sx, gotB, pixelModel(sx, oy + 3, ox, oy, shown, 1'b0));
      end
      step(1);
    end
  endtask

  task automatic test_latency();
    int v;
    v = $urandom_range(1, 9999);
    applyStimulus(v);
    frame = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tests++;
      if (busyA !== 1'b1) begin
        fails++;
        $display("[TB] FAIL latency_conv_busy cycle=%0d got=%b want=1", k, busyA);
      end
      step(1);
    end
    setPixel(ox + 60, oy + 1);
    tests++;
    if ({busyA, gotA} !== {1'b1, pixelModel(ox + 60, oy + 1, ox, oy, shown, 1'b1)}) begin
      fails++;
      $display("[TB] FAIL latency_first_pend got=%b_%h want=1_%h", busyA, gotA, pixelModel(ox + 60, oy + 1, ox, oy, shown, 1'b1));
    end
    step(1);
    frame = 1'b0;
    shown = v;
    tests++;
    if ({busyA, gotA} !== {1'b0, pixelModel(ox + 60, oy + 1, ox, oy, shown, 1'b1)}) begin
      fails++;
      $display("[TB] FAIL latency_commit got=%b_%h want=0_%h", busyA, gotA, pixelModel(ox + 60, oy + 1, ox, oy, shown, 1'b1));
    end
  endtask

  task automatic test_saturate();
    int vals[3] = '{12000, 10000, 9999};
    foreach (vals[n]) begin
      applyStimulus(vals[n]);
      step(15);
      pulseFrame();
      shown = satModel(vals[n]);
      for (int sx = ox - 2; sx <= ox + 81; sx++) begin
        setPixel(sx, oy + 10);
        tests++;
        if (gotA !== pixelModel(sx, oy + 10, ox, oy, shown, 1'b1)) begin
          fails++;
          $display("[TB] FAIL saturate v=%0d sx=%0d got=%h want=%h", vals[n], sx, gotA, pixelModel(sx, oy + 10, ox, oy, shown, 1'b1));
        end
        step(1);
      end
    end
  endtask

  task automatic test_leading_zero();
    int vals[5] = '{7, 0, 50, 305, 1000};
    foreach (vals[n]) begin
      applyStimulus(vals[n]);
      step(16);
      pulseFrame();
      shown = vals[n];
      for (int sx = ox - 2; sx <= ox + 81; sx++) begin
        setPixel(sx, oy + 19);
        tests += 2;
        if (gotA !== pixelModel(sx, oy + 19, ox, oy, shown, 1'b1)) begin
          fails++;
          $display("[TB] FAIL lzero_lz v=%0d sx=%0d got=%h want=%h", vals[n], sx, gotA, pixelModel(sx, oy + 19, ox, oy, shown, 1'b1));
        end
        if (gotB !== pixelModel(sx, oy + 19, ox, oy, shown, 1'b0)) begin
          fails++;
          $display("[TB] FAIL lzero_nolz v=%0d sx=%0d got=%h want=%h", vals[n], sx, gotB, pixelModel(sx, oy + 19, ox, oy, shown, 1'b0));
        end
        step(1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int a, b;
    a = $urandom_range(0, 9999);
    b = $urandom_range(0, 16383);
    applyStimulus(a);
    valueValid = 1'b1;
    value = BIN_W'(b);
    for (int c = 1; c <= 20; c++) begin
      frame = (c == 8);
      tests++;
      if ({readyA, busyA, readyB, busyB} !== 4'b0101) begin
        fails++;
        $display("[TB] FAIL b2b_offer cycle=%0d got=%b want=0101", c, {readyA, busyA, readyB, busyB});
      end
      step(1);
    end
    frame = 1'b0;
    valueValid = 1'b0;
    setPixel(ox + 60, oy + 2);
    tests++;
    if (gotA !== pixelModel(ox + 60, oy + 2, ox, oy, shown, 1'b1)) begin
      fails++;
      $display("[TB] FAIL b2b_hold_old got=%h want=%h", gotA, pixelModel(ox + 60, oy + 2, ox, oy, shown, 1'b1));
    end
    pulseFrame();
    shown = a;
    step(2);
    tests++;
    if ({readyA, busyA} !== 2'b10) begin
      fails++;
      $display("[TB] FAIL b2b_idle_after got=%b want=10", {readyA, busyA});
    end
    for (int sx = ox - 2; sx <= ox + 81; sx++) begin
      setPixel(sx, oy + 7);
      tests++;
      if (gotA !== pixelModel(sx, oy + 7, ox, oy, shown, 1'b1)) begin
        fails++;
        $display("[TB] FAIL b2b_sweep sx=%0d got=%h want=%h", sx, gotA, pixelModel(sx, oy + 7, ox, oy, shown, 1'b1));
      end
      step(1);
    end
  endtask

  task automatic test_reset_mid_conv();
    applyStimulus(4321);
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    shown = 0;
    tests++;
    if ({readyA, busyA, readyB, busyB} !== 4'b1010) begin
      fails++;
      $display("[TB] FAIL rstconv_handshake got=%b want=1010", {readyA, busyA, readyB, busyB});
    end
    for (int f = 0; f < 3; f++) begin
      step(20);
      pulseFrame();
      tests++;
      if (busyA !== 1'b0) begin
        fails++;
        $display("[TB] FAIL rstconv_busy frame=%0d got=%b want=0", f, busyA);
      end
    end
    for (int sx = ox - 2; sx <= ox + 81; sx++) begin
      setPixel(sx, oy + 4);
      tests++;
      if (gotA !== pixelModel(sx, oy + 4, ox, oy, shown, 1'b1)) begin
        fails++;
        $display("[TB] FAIL rstconv_sweep sx=%0d got=%h want=%h", sx, gotA, pixelModel(sx, oy + 4, ox, oy, shown, 1'b1));
      end
      step(1);
    end
  endtask

  task automatic test_random();
    int v, sy;
    for (int n = 0; n < 8; n++) begin
      setOrigin($urandom_range(2, 900), $urandom_range(2, 990));
      v = $urandom_range(0, 16383) >> $urandom_range(0, 13);
      applyStimulus(v);
      for (int c = 1; c <= 14; c++) begin
        frame = 1'($urandom_range(0, 1));
        step(1);
      end
      frame = 1'b0;
      tests++;
      if (busyA !== 1'b1) begin
        fails++;
        $display("[TB] FAIL random_pend_busy v=%0d got=%b want=1", v, busyA);
      end
      step($urandom_range(0, 5));
      pulseFrame();
      shown = satModel(v);
      for (int sx = ox - 2; sx <= ox + 81; sx++) begin
        sy = $urandom_range(oy - 2, oy + 22);
        setPixel(sx, sy);
        tests += 2;
        if (gotA !== pixelModel(sx, sy, ox, oy, shown, 1'b1)) begin
          fails++;
          $display("[TB] FAIL random_lz v=%0d sx=%0d sy=%0d got=%h want=%h", v, sx, sy, gotA, pixelModel(sx, sy, ox, oy, shown, 1'b1));
        end
        if (gotB !== pixelModel(sx, sy, ox, oy, shown, 1'b0)) begin
          fails++;
          $display("[TB] FAIL random_nolz v=%0d sx=%0d sy=%0d got=%h want=%h", v, sx, sy, gotB, pixelModel(sx, sy, ox, oy, shown, 1'b0));
        end
        step(1);
      end
    end
  endtask

  task automatic test_no_lz();
    setOrigin(100, 50);
    applyStimulus(5);
    step(16);
    pulseFrame();
    shown = 5;
    setPixel(100, 55);
    tests++;
    if (gotB !== {1'b1, 4'd0, 10'd100, 10'd50}) begin
      fails++;
      $display("[TB] FAIL nolz_slot0 got=%h want=%h", gotB, {1'b1, 4'd0, 10'd100, 10'd50});
    end
    setPixel(160, 55);
    tests++;
    if (gotB !== {1'b1, 4'd5, 10'd160, 10'd50}) begin
      fails++;
      $display("[TB] FAIL nolz_slot3 got=%h want=%h", gotB, {1'b1, 4'd5, 10'd160, 10'd50});
    end
    for (int sx = ox - 2; sx <= ox + 81; sx++) begin
      setPixel(sx, oy + 20);
      tests += 2;
      if (enA !== 1'b0 || enB !== 1'b0) begin
        fails++;
        $display("[TB] FAIL nolz_below_row sx=%0d got=%b%b want=00", sx, enA, enB);
      end
      setPixel(sx, oy + 12);
      if (gotB !== pixelModel(sx, oy + 12, ox, oy, shown, 1'b0)) begin
        fails++;
        $display("[TB] FAIL nolz_sweep sx=%0d got=%h want=%h", sx, gotB, pixelModel(sx, oy + 12, ox, oy, shown, 1'b0));
      end
      step(1);
    end
  endtask

  // Test sequence and summary.
  initial begin
    test_reset();
    test_load_1234();
    test_latency();
    test_saturate();
    test_leading_zero();
    test_back_to_back();
    test_reset_mid_conv();
    test_random();
    test_no_lz();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
